hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Generates write-enable and flush controls for PC, IF_ID, ID_EX and EX_MEM from four hazard sources: load-use hazards, branch mispredicts, multi-cycle MUL/DIV occupancy and memory stall requests.
- Holds a small FSM so that multi-cycle freezes and deferred flushes are sequenced correctly.
- Sits beside the pipeline registers, driven by the ID, EX and MEM stages.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_lu_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its helpers.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // Canonical NOP (addi x0, x0, 0) loaded by the pipeline registers on flush.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use comparator: an ID source register matches the destination of a load in EX.
module lu_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  lu
);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign lu = mem_read && (rd != '0) &&
              ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush enables for PC, IF_ID, ID_EX and EX_MEM.
module hazard_ctrl #(
  parameter int REG_ADDR_W = hazard_ctrl_pkg::REG_ADDR_W,
  parameter int MD_MAX_CYC = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_Use_Rs1,
  input  logic                  ID_Use_Rs2,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_Mispredict,
  input  logic                  EX_MD_Start,
  input  logic                  MD_Done,
  input  logic                  MEM_Stall_Req,
  output logic                  PC_w,
  output logic                  IF_ID_w,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_w,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_w,
  output logic                  EX_MEM_Bubble,
  output logic                  MD_Timeout,
  output logic [CNT_W-1:0]      Stall_Cnt
);

  import hazard_ctrl_pkg::*;

  localparam int                   MD_CNT_W = $clog2(MD_MAX_CYC);
  localparam logic [MD_CNT_W-1:0]  MD_LAST  = MD_CNT_W'(MD_MAX_CYC - 1);

  state_t              st, st_nxt;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic                pend_flush, pend_flush_nxt;
  logic                timeout_set;
  logic                lu;

  lu_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu_detect (
    .rs1      (ID_Rs1),
    .rs2      (ID_Rs2),
    .use_rs1  (ID_Use_Rs1),
    .use_rs2  (ID_Use_Rs2),
    .mem_read (EX_MemRead),
    .rd       (EX_Rd),
    .lu       (lu)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    PC_w           = 1'b1;
    IF_ID_w        = 1'b1;
    IF_ID_Flush    = 1'b0;
    ID_EX_w        = 1'b1;
    ID_EX_Flush    = 1'b0;
    EX_MEM_w       = 1'b1;
    EX_MEM_Bubble  = 1'b0;
    st_nxt         = st;
    md_cnt_nxt     = md_cnt;
    pend_flush_nxt = pend_flush;
    timeout_set    = 1'b0;

    if (rst) begin
      PC_w     = 1'b0;
      IF_ID_w  = 1'b0;
      ID_EX_w  = 1'b0;
      EX_MEM_w = 1'b0;
    end else begin
      unique case (st)
        ST_RUN: begin
          if (MEM_Stall_Req) begin
            PC_w           = 1'b0;
            IF_ID_w        = 1'b0;
            ID_EX_w        = 1'b0;
            EX_MEM_w       = 1'b0;
            st_nxt         = ST_MEM_WAIT;
            pend_flush_nxt = pend_flush | EX_Mispredict;
          end else if (EX_Mispredict || pend_flush) begin
            IF_ID_Flush    = 1'b1;
            ID_EX_Flush    = 1'b1;
            pend_flush_nxt = 1'b0;
          end else if (EX_MD_Start) begin
            PC_w          = 1'b0;
            IF_ID_w       = 1'b0;
            ID_EX_w       = 1'b0;
            EX_MEM_Bubble = 1'b1;
            st_nxt        = ST_MD_WAIT;
            md_cnt_nxt    = MD_CNT_W'(1);
          end else if (lu) begin
            PC_w        = 1'b0;
            IF_ID_w     = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end

        ST_MD_WAIT: begin
          if (MEM_Stall_Req) begin
            // Memory stall outranks release; the counter saturates at the limit so the
            // watchdog still fires once memory frees up.
            PC_w          = 1'b0;
            IF_ID_w       = 1'b0;
            ID_EX_w       = 1'b0;
            EX_MEM_w      = 1'b0;
            EX_MEM_Bubble = 1'b1;
            if (md_cnt != MD_LAST) md_cnt_nxt = md_cnt + 1'b1;
          end else if (MD_Done || (md_cnt == MD_LAST)) begin
            timeout_set = !MD_Done;
            st_nxt      = ST_RUN;
            md_cnt_nxt  = '0;
          end else begin
            PC_w          = 1'b0;
            IF_ID_w       = 1'b0;
            ID_EX_w       = 1'b0;
            EX_MEM_Bubble = 1'b1;
            md_cnt_nxt    = md_cnt + 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          PC_w     = 1'b0;
          IF_ID_w  = 1'b0;
          ID_EX_w  = 1'b0;
          EX_MEM_w = 1'b0;
          if (!MEM_Stall_Req) st_nxt = ST_RUN;
        end

        default: st_nxt = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_RUN;
      md_cnt     <= '0;
      pend_flush <= 1'b0;
      MD_Timeout <= 1'b0;
      Stall_Cnt  <= '0;
    end else begin
      st         <= st_nxt;
      md_cnt     <= md_cnt_nxt;
      pend_flush <= pend_flush_nxt;
      if (timeout_set) MD_Timeout <= 1'b1;
      if (!PC_w && (Stall_Cnt != {CNT_W{1'b1}})) Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end

endmodule
